fetch_align_buffer: RTL and testbench

FETCH_ALIGN_BUFFER -- requirements
Module: fetch_align_buffer

---
 rtl/fetch_align_buffer.sv | 123 ++++++++++++
 tb/tb_fetch_align_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer
//   Realigns a stream of 32-bit fetch words into a stream of complete
//   RISC-V instructions. An instruction is either a 16-bit compressed one or
//   a 32-bit one, and a 32-bit instruction may start in one word and end in
//   the next. Buffered halfwords sit in a 4-entry FIFO (h0 oldest), and the
//   occupancy count is the only control state.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   fetch_pc            word-aligned address of the next word requested
//   fetch_valid/ready   fetch word handshake; fetch_data halfword 0 = [15:0]
//   redirect            one-cycle flush to redirect_pc (halfword aligned)
//   inst_valid/ready    instruction handshake
//   inst_data           {16'b0,h0} if compressed, else {h1,h0}
//   inst_pc             address of the instruction on inst_data
//   inst_is_compressed  h0[1:0] != 2'b11
module fetch_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_is_compressed
);

  // Halfword i of the FIFO lives at hbuf[16*i +: 16].
  logic [63:0] hbuf;
  logic [63:0] hbuf_next;
  logic [2:0]  count;
  logic [2:0]  count_next;
  // Set when a redirect/reset targets the upper half of a word: the low
  // halfword of the next accepted word lies before the target and is dropped.
  logic        drop_low;

  logic [15:0] h0;
  logic [15:0] h1;
  logic        h0_compressed;
  logic        accept;
  logic        pop;

  logic [2:0]  pop_n;
  logic [2:0]  app_n;
  logic [31:0] app_word;
  logic [2:0]  keep;
  logic [63:0] keep_mask;
  logic [63:0] shifted;
  logic [63:0] appended;

  assign h0            = hbuf[15:0];
  assign h1            = hbuf[31:16];
  assign h0_compressed = (h0[1:0] != 2'b11);

  assign fetch_ready        = (count <= 3'd2) && !redirect;
  assign inst_valid         = !redirect &&
                              (((count >= 3'd1) && h0_compressed) || (count >= 3'd2));
  assign inst_is_compressed = h0_compressed;
  assign inst_data          = h0_compressed ? {16'b0, h0} : {h1, h0};

  assign accept = fetch_valid && fetch_ready;
  assign pop    = inst_valid && inst_ready;

  // Pop from the head and append behind the surviving entries in one step.
  // Appends only happen with count <= 2, so the result never exceeds 4.
  always_comb begin
    pop_n    = '0;
    app_n    = '0;
    app_word = '0;
    if (pop) begin
      pop_n = h0_compressed ? 3'd1 : 3'd2;
    end
    if (accept) begin
      if (drop_low) begin
        app_n    = 3'd1;
        app_word = {16'b0, fetch_data[31:16]};
      end else begin
        app_n    = 3'd2;
        app_word = fetch_data;
      end
    end
    keep       = count - pop_n;
    keep_mask  = ~({64{1'b1}} << {keep, 4'b0000});
    shifted    = hbuf >> {pop_n, 4'b0000};
    appended   = {32'b0, app_word} << {keep, 4'b0000};
    hbuf_next  = (shifted & keep_mask) | (appended & ~keep_mask);
    count_next = keep + app_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      hbuf     <= '0;
      inst_pc  <= RESET_PC;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      drop_low <= RESET_PC[1];
    end else if (redirect) begin
      count    <= '0;
      hbuf     <= '0;
      inst_pc  <= redirect_pc;
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      drop_low <= redirect_pc[1];
    end else begin
      count <= count_next;
      hbuf  <= hbuf_next;
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
        drop_low <= 1'b0;
      end
      if (pop) begin
        inst_pc <= inst_pc + (h0_compressed ? 32'd2 : 32'd4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: vector table of fetch words with expected
// instructions, plus short sequences for backpressure, flush and reset.
module tb_fetch_align_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;

  fetch_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .reset              (reset),
    .fetch_pc           (fetch_pc),
    .fetch_valid        (fetch_valid),
    .fetch_data         (fetch_data),
    .fetch_ready        (fetch_ready),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .inst_valid         (inst_valid),
    .inst_ready         (inst_ready),
    .inst_data          (inst_data),
    .inst_pc            (inst_pc),
    .inst_is_compressed (inst_is_compressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  typedef struct {
    logic [31:0]       start_pc;
    logic [31:0]       w0;
    logic [31:0]       w1;
    int                n;
    logic [2:0][31:0]  ed;
    logic [2:0][31:0]  ep;
    logic [2:0]        ec;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[6];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] sp, input logic [31:0] w0, input logic [31:0] w1,
                              input int n,
                              input logic [31:0] d0, input logic [31:0] p0, input logic c0,
                              input logic [31:0] d1, input logic [31:0] p1, input logic c1,
                              input logic [31:0] d2, input logic [31:0] p2, input logic c2);
    vec_t v;
    v.start_pc = sp;
    v.w0 = w0;
    v.w1 = w1;
    v.n  = n;
    v.ed[0] = d0; v.ep[0] = p0; v.ec[0] = c0;
    v.ed[1] = d1; v.ep[1] = p1; v.ec[1] = c1;
    v.ed[2] = d2; v.ep[2] = p2; v.ec[2] = c2;
    return v;
  endfunction

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    fetch_valid = 1'b0;
    @(negedge clk);
    chk("redirect_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("redirect_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    widx;
    int    cyc;
    exp_t  e;
    logic [31:0] base;
    do_redirect(v.start_pc);
    base = {v.start_pc[31:2], 2'b00};
    for (int k = 0; k < v.n; k++) begin
      e.data = v.ed[k];
      e.pc   = v.ep[k];
      e.c    = v.ec[k];
      sbq.push_back(e);
    end
    inst_ready = 1'b1;
    widx = 0;
    cyc  = 0;
    while (sbq.size() > 0 && cyc < 40) begin
      fetch_valid = (widx < 2);
      fetch_data  = (widx == 0) ? v.w0 : v.w1;
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL v%0d_extra_inst actual=%h required=none", idx, inst_data);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("v%0d_data", idx), inst_data, e.data);
          chk($sformatf("v%0d_pc", idx), inst_pc, e.pc);
          chk($sformatf("v%0d_comp", idx), {31'b0, inst_is_compressed}, {31'b0, e.c});
        end
      end
      if (fetch_valid && fetch_ready) begin
        chk($sformatf("v%0d_fetch_pc", idx), fetch_pc, base + 32'(4 * widx));
        widx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL v%0d_timeout actual=%0d_left required=0", idx, sbq.size());
      sbq.delete();
    end
    fetch_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int acc;
    int cyc;

    vt[0] = mk(32'h0000_0000, 32'h0000_4501, 32'h0051_0513, 3,
               32'h0000_4501, 32'h0000_0000, 1'b1,
               32'h0000_0000, 32'h0000_0002, 1'b1,
               32'h0051_0513, 32'h0000_0004, 1'b0);
    vt[1] = mk(32'h0000_0000, 32'h0513_4501, 32'h4505_0051, 3,
               32'h0000_4501, 32'h0000_0000, 1'b1,
               32'h0051_0513, 32'h0000_0002, 1'b0,
               32'h0000_4505, 32'h0000_0006, 1'b1);
    vt[2] = mk(32'h0000_0102, 32'hAAAA_4501, 32'h0000_0001, 3,
               32'h0000_AAAA, 32'h0000_0102, 1'b1,
               32'h0000_0001, 32'h0000_0104, 1'b1,
               32'h0000_0000, 32'h0000_0106, 1'b1);
    vt[3] = mk(32'hFFFF_FFFC, 32'h0000_0013, 32'h0000_4505, 3,
               32'h0000_0013, 32'hFFFF_FFFC, 1'b0,
               32'h0000_4505, 32'h0000_0000, 1'b1,
               32'h0000_0000, 32'h0000_0002, 1'b1);
    vt[4] = mk(32'h0000_0200, 32'h1234_5677, 32'h0000_0001, 3,
               32'h1234_5677, 32'h0000_0200, 1'b0,
               32'h0000_0001, 32'h0000_0204, 1'b1,
               32'h0000_0000, 32'h0000_0206, 1'b1);
    vt[5] = mk(32'h0000_0302, 32'h0003_FFFF, 32'hABCD_8765, 2,
               32'h8765_0003, 32'h0000_0302, 1'b0,
               32'h0000_ABCD, 32'h0000_0306, 1'b1,
               32'h0000_0000, 32'h0000_0000, 1'b0);

    reset       = 1'b1;
    fetch_valid = 1'b0;
    fetch_data  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("reset_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    chk("reset_fetch_pc", fetch_pc, 32'h0000_0000);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vt[i], i);
    end

    // Backpressure: fill to four halfwords with the consumer stalled.
    do_redirect(32'h0000_0000);
    inst_ready  = 1'b0;
    fetch_valid = 1'b1;
    fetch_data  = 32'h0000_4501;
    acc = 0;
    cyc = 0;
    while (acc < 2 && cyc < 10) begin
      @(negedge clk);
      if (fetch_valid && fetch_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_fetch_ready", {31'b0, fetch_ready}, 32'd0);
      chk("bp_fetch_pc", fetch_pc, 32'h0000_0008);
      chk("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_inst_data", inst_data, 32'h0000_4501);
      chk("bp_inst_pc", inst_pc, 32'h0000_0000);
      @(posedge clk); #1;
    end

    // Flush from a full buffer.
    do_redirect(32'h0000_0102);
    @(negedge clk);
    chk("flush_fetch_pc", fetch_pc, 32'h0000_0100);
    chk("flush_inst_valid", {31'b0, inst_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset and redirect together: reset values win.
    reset       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0502;
    @(posedge clk); #1;
    reset    = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    chk("rr_fetch_pc", fetch_pc, 32'h0000_0000);
    chk("rr_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rr_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    @(posedge clk); #1;
    fetch_valid = 1'b1;
    fetch_data  = 32'h0000_4501;
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      if (inst_valid) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rr_first_valid", {31'b0, inst_valid}, 32'd1);
    chk("rr_first_pc", inst_pc, 32'h0000_0000);
    chk("rr_first_data", inst_data, 32'h0000_4501);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-stream discards buffered halfwords.
    fetch_valid = 1'b0;
    reset       = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_reset_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("mid_reset_fetch_pc", fetch_pc, 32'h0000_0000);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
